// File: rtl/fixed_to_float_seq_if.sv
// fixed_to_float_seq_if: enable/done handshake and operand/result bus of the fixed-to-float converter
interface fixed_to_float_seq_if #(
   parameter int WIDTH = 22
);
   logic             enable;
   logic [WIDTH-1:0] data;
   logic [31:0]      result;
   logic             done;
   logic             busy;
   modport master (output enable, data, input result, done, busy);
   modport slave  (input enable, data, output result, done, busy);
endinterface

// File: rtl/fixed_to_float_seq.sv
// fixed_to_float_seq: iterative signed fixed-point to IEEE-754 single converter, one normalisation bit per clock
module fixed_to_float_seq #(
   parameter int WIDTH     = 22,
   parameter int FRAC_BITS = 20
) (
   input  logic               clk,
   input  logic               reset,
   fixed_to_float_seq_if.slave bus
);
   localparam int KW   = $clog2(WIDTH);
   localparam int EXP0 = 127 + WIDTH - 1 - FRAC_BITS;
   typedef enum logic [1:0] {IDLE, ABS, NORM, PACK} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_data, r_mag;
   logic [KW-1:0]    r_k;
   logic             r_sign, r_done, w_busy;
   logic [31:0]      r_result, w_packed;
   logic [7:0]       w_exp;
   logic [22:0]      w_mant;
   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end
   // next state: normalisation stops once the magnitude MSB is set; zero skips it entirely
   always_comb begin
      w_next = (r_state == IDLE) ? (bus.enable ? ABS : IDLE) :
               (r_state == ABS)  ? ((r_data == '0) ? PACK : NORM) :
               (r_state == NORM) ? (r_mag[WIDTH-1] ? PACK : NORM) : IDLE;
   end
   // outputs and packed float; the leading one is implicit so only the bits below it form the mantissa
   always_comb begin
      w_busy   = (r_state != IDLE);
      w_exp    = 8'(EXP0 - int'(r_k));
      w_mant   = 23'(r_mag[WIDTH-2:0]) << (24 - WIDTH);
      w_packed = (r_mag == '0) ? 32'h0 : {r_sign, w_exp, w_mant};
   end
   // datapath: capture, magnitude, shift-and-count, result register and done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data   <= '0;
         r_mag    <= '0;
         r_k      <= '0;
         r_sign   <= 1'b0;
         r_result <= 32'h0;
         r_done   <= 1'b0;
      end else begin
         r_done <= (r_state == PACK);
         case (r_state)
            IDLE: if (bus.enable) r_data <= bus.data;
            ABS: begin
               r_sign <= r_data[WIDTH-1];
               r_mag  <= r_data[WIDTH-1] ? -r_data : r_data;
               r_k    <= '0;
            end
            NORM: if (!r_mag[WIDTH-1]) begin
               r_mag <= r_mag << 1;
               r_k   <= r_k + 1'b1;
            end
            PACK: r_result <= w_packed;
         endcase
      end
   end
   assign bus.result = r_result;
   assign bus.done   = r_done;
   assign bus.busy   = w_busy;
endmodule

// File: tb/tb_fixed_to_float_seq.sv
// tb_fixed_to_float_seq: random and directed checks of the converter against a real-arithmetic reference
module tb_fixed_to_float_seq;
   localparam int W = 22;
   localparam int F = 20;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   fixed_to_float_seq_if #(.WIDTH(W)) bus();
   fixed_to_float_seq #(.WIDTH(W), .FRAC_BITS(F)) dut (.clk(clk), .reset(reset), .bus(bus));
   int          n_cmp = 0;
   int          n_err = 0;
   longint      cyc = 0;
   logic        chk_en = 1'b0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_result = 32'h0;
   logic [31:0] m_pend = 32'h0;
   longint      m_due = 0;
   // binary exponent of a positive real
   function automatic int fexp(real a);
      int e = 0;
      while (a >= 2.0) begin
         a = a / 2.0;
         e++;
      end
      while (a < 1.0) begin
         a = a * 2.0;
         e--;
      end
      return e;
   endfunction
   // exact float encoding of signed(d) * 2^-F
   function automatic logic [31:0] ref_f(logic [W-1:0] d);
      int  v;
      int  e;
      int  mant;
      real a;
      v = $signed(d);
      if (v == 0) return 32'h0;
      a = $itor(v) / $itor(1 << F);
      if (a < 0.0) a = -a;
      e = fexp(a);
      mant = int'((a / (2.0 ** e) - 1.0) * 8388608.0);
      return {v < 0, 8'(e + 127), 23'(mant)};
   endfunction
   // cycles from the accepting edge to the edge that raises done
   function automatic int ref_lat(logic [W-1:0] d);
      int  v;
      real a;
      v = $signed(d);
      if (v == 0) return 2;
      a = $itor(v < 0 ? -v : v) / $itor(1 << F);
      return 3 + (W - 1) - (fexp(a) + F);
   endfunction
   task automatic check(string name, logic [31:0] got, logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask
   // reference timing model: busy until the due edge, then a one-cycle done with the held result
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         m_busy   <= 1'b0;
         m_done   <= 1'b0;
         m_result <= 32'h0;
      end else begin
         if (m_busy && cyc == m_due) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b1;
            m_result <= m_pend;
         end else begin
            m_done <= 1'b0;
         end
         if (!m_busy && bus.enable) begin
            m_busy <= 1'b1;
            m_due  <= cyc + ref_lat(bus.data);
            m_pend <= ref_f(bus.data);
         end
      end
   end
   // every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("done", 32'(bus.done), 32'(m_done));
         check("busy", 32'(bus.busy), 32'(m_busy));
         check("result", bus.result, m_result);
      end
   end
   task automatic wait_idle();
      for (int i = 0; i < 40 && m_busy; i++) @(negedge clk);
      n_cmp++;
      if (m_busy) begin
         n_err++;
         $display("FAIL timeout: busy 1 expected 0");
      end
   endtask
   task automatic op(logic [W-1:0] d);
      bus.enable = 1'b1;
      bus.data   = d;
      @(negedge clk);
      bus.enable = 1'b0;
      bus.data   = W'($urandom);
      wait_idle();
   endtask
   initial begin
      bus.enable = 1'b0;
      bus.data   = '0;
      @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_result", bus.result, 32'h0);
      check("rst_done", 32'(bus.done), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      reset = 1'b0;
      check("pin_p1", ref_f(22'h100000), 32'h3F800000);
      check("pin_m1", ref_f(22'h300000), 32'hBF800000);
      check("pin_half", ref_f(22'h080000), 32'h3F000000);
      check("pin_m2", ref_f(22'h200000), 32'hC0000000);
      check("pin_lsb", ref_f(22'h000001), 32'h35800000);
      check("pin_zero", ref_f(22'h000000), 32'h00000000);
      check("lat_p1", 32'(ref_lat(22'h100000)), 32'd4);
      check("lat_half", 32'(ref_lat(22'h080000)), 32'd5);
      check("lat_m2", 32'(ref_lat(22'h200000)), 32'd3);
      check("lat_lsb", 32'(ref_lat(22'h000001)), 32'd24);
      check("lat_zero", 32'(ref_lat(22'h000000)), 32'd2);
      op(22'h100000);
      op(22'h300000);
      op(22'h080000);
      op(22'h200000);
      op(22'h000001);
      op(22'h000000);
      bus.enable = 1'b1;
      bus.data   = 22'h100000;
      @(negedge clk);
      bus.enable = 1'b0;
      @(negedge clk);
      bus.enable = 1'b1;
      bus.data   = 22'h080000;
      @(negedge clk);
      bus.enable = 1'b0;
      wait_idle();
      bus.enable = 1'b1;
      bus.data   = 22'h100000;
      @(negedge clk);
      bus.data = 22'h080000;
      repeat (8) @(negedge clk);
      bus.enable = 1'b0;
      wait_idle();
      bus.enable = 1'b1;
      bus.data   = 22'h000001;
      @(negedge clk);
      bus.enable = 1'b0;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_result", bus.result, 32'h0);
      check("abort_busy", 32'(bus.busy), 32'h0);
      repeat (30) @(negedge clk);
      op(22'h100000);
      repeat (4000) begin
         int r;
         reset      = ($urandom_range(0, 399) == 0);
         bus.enable = ($urandom_range(0, 2) == 0);
         r = $urandom_range(0, 7);
         bus.data = (r == 0) ? W'(0) : (r == 1) ? 22'h200000 :
                    (r == 2) ? W'(1 << $urandom_range(0, W - 1)) : W'($urandom);
         @(negedge clk);
      end
      reset      = 1'b0;
      bus.enable = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
